// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // RUN: every response is kept. FLUSH: responses from before a redirect are still returning.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    // Force an address onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer: DEPTH entries, push/pop in the same cycle, and a
// synchronous flush that takes priority over both.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ADDR_W + INST_W,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Pointer advance with wrap, valid for any DEPTH (not only powers of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(DEPTH - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Qualify push/pop: a pop frees the slot a push into a full buffer needs.
    always_comb begin
        full_s    = (count_r == CNT_W'(DEPTH));
        pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
        push_ok_s = push && (!full_s || pop_ok_s);
    end

    // Entry storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign empty     = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches under a credit limit
// (buffered + in-flight <= DEPTH), buffers in-order responses with their PCs,
// and on redirect discards buffered work and drops responses still in flight.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int ENT_W = ADDR_W + INST_W;

    fetch_state_e      state_r;
    fetch_state_e      state_nxt_s;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] fetch_pc_nxt_s;
    logic [ADDR_W-1:0] resp_pc_r;
    logic [ADDR_W-1:0] resp_pc_nxt_s;
    logic [CNT_W-1:0]  outstanding_r;
    logic [CNT_W-1:0]  outstanding_nxt_s;
    logic [CNT_W-1:0]  drop_cnt_r;
    logic [CNT_W-1:0]  drop_cnt_nxt_s;

    logic [SUM_W-1:0]  credit_used_s;
    logic              mem_req_s;
    logic              grant_s;
    logic              resp_s;
    logic              drop_s;
    logic              push_s;
    logic              pop_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_empty_s;
    logic [ENT_W-1:0]  fifo_head_s;

    // Issue only while a buffer slot is guaranteed for the response; never during redirect or reset.
    always_comb begin
        credit_used_s = {1'b0, fifo_count_s} + {1'b0, outstanding_r};
        mem_req_s     = 1'b0;
        if (!rst && !redirect && (credit_used_s < SUM_W'(DEPTH))) begin
            mem_req_s = 1'b1;
        end else begin
            mem_req_s = 1'b0;
        end
        grant_s = mem_req_s && mem_gnt;
    end

    // Classify this cycle's response and consumer handshake; stray responses with nothing in flight are ignored.
    always_comb begin
        resp_s = mem_rvalid && (outstanding_r != {CNT_W{1'b0}});
        drop_s = resp_s && (state_r == FLUSH);
        push_s = resp_s && !drop_s && !redirect;
        pop_s  = !fifo_empty_s && inst_ready && !redirect;
    end

    // Next values for the PCs and the in-flight / to-drop counters.
    always_comb begin
        fetch_pc_nxt_s    = fetch_pc_r;
        resp_pc_nxt_s     = resp_pc_r;
        drop_cnt_nxt_s    = drop_cnt_r;
        outstanding_nxt_s = outstanding_r + CNT_W'(grant_s) - CNT_W'(resp_s);
        if (redirect) begin
            fetch_pc_nxt_s = align_pc(redirect_addr);
            resp_pc_nxt_s  = align_pc(redirect_addr);
            // Everything still in flight after this cycle belongs to the old path.
            drop_cnt_nxt_s = outstanding_r - CNT_W'(resp_s);
        end else begin
            if (grant_s) begin
                fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end
            if (push_s) begin
                resp_pc_nxt_s = resp_pc_r + PC_STEP;
            end else begin
                resp_pc_nxt_s = resp_pc_r;
            end
            if (drop_s) begin
                drop_cnt_nxt_s = drop_cnt_r - CNT_W'(1);
            end else begin
                drop_cnt_nxt_s = drop_cnt_r;
            end
        end
    end

    // RUN/FLUSH transitions; a redirect recomputes the drop count rather than adding to it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RUN: begin
                if (redirect && (drop_cnt_nxt_s != {CNT_W{1'b0}})) begin
                    state_nxt_s = FLUSH;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FLUSH: begin
                if (redirect) begin
                    state_nxt_s = (drop_cnt_nxt_s != {CNT_W{1'b0}}) ? FLUSH : RUN;
                end else if (drop_s && (drop_cnt_r == CNT_W'(1))) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // Fetch state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= RUN;
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= {CNT_W{1'b0}};
            drop_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            fetch_pc_r    <= fetch_pc_nxt_s;
            resp_pc_r     <= resp_pc_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            drop_cnt_r    <= drop_cnt_nxt_s;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data ({resp_pc_r, mem_rdata}),
        .pop       (pop_s),
        .flush     (redirect),
        .head_data (fifo_head_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s)
    );

    assign mem_req    = mem_req_s;
    assign mem_addr   = fetch_pc_r;
    assign inst_valid = !fifo_empty_s;
    assign inst_addr  = fifo_head_s[ENT_W-1:INST_W];
    assign inst       = fifo_head_s[INST_W-1:0];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, word-aligned PC loaded on reset.
REQ-002 Parameter: DEPTH, 2, instruction buffer entries and maximum outstanding memory requests.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: mem_req  output  1  fetch request valid toward instruction memory.
REQ-006 Port: mem_addr  output  32  word-aligned fetch address; valid while mem_req=1.
REQ-007 Port: mem_gnt  input  1  memory accepts the request this cycle.
REQ-008 Port: mem_rvalid  input  1  read data returned this cycle, in request order.
REQ-009 Port: mem_rdata  input  32  returned instruction word.
REQ-010 Port: inst_valid  output  1  buffered instruction available to the CPU.
REQ-011 Port: inst  output  32  instruction at the buffer head.
REQ-012 Port: inst_addr  output  32  PC of inst; inst_addr+4 is the sequential next PC.
REQ-013 Port: inst_ready  input  1  CPU consumes the head entry.
REQ-014 Port: redirect  input  1  branch/jump taken; discard all fetched and in-flight work.
REQ-015 Port: redirect_addr  input  32  new PC; bits [1:0] are ignored and forced to 0.

Function
REQ-016 The block SHALL keep fetch_pc (next issue address), resp_pc (PC of the next accepted response), outstanding (0..DEPTH), drop_cnt (0..DEPTH) and a DEPTH-entry FIFO of {addr, data}.
REQ-017 mem_req SHALL be 1 exactly when redirect=0 and fifo_count+outstanding < DEPTH; mem_addr SHALL equal fetch_pc.
REQ-018 On mem_req&&mem_gnt, fetch_pc SHALL increase by 4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000) and outstanding SHALL increment.
REQ-019 On mem_rvalid, outstanding SHALL decrement; if drop_cnt>0, the response SHALL be discarded and drop_cnt decremented, otherwise {resp_pc, mem_rdata} SHALL be pushed and resp_pc increased by 4.
REQ-020 Grant and response in the same cycle SHALL leave outstanding unchanged.
REQ-021 mem_rvalid while outstanding=0 is a protocol violation and SHALL be ignored without any state change.
REQ-022 inst_valid SHALL equal FIFO non-empty; head pops on inst_valid&&inst_ready; push and pop in the same cycle are both honoured.
REQ-023 Latency: a response accepted in cycle N SHALL appear on inst_valid/inst in cycle N+1 at the earliest.
REQ-024 The FIFO SHALL never overflow; REQ-017 credit accounting guarantees this, and no push is lost when full-with-pop.
REQ-025 FSM states SHALL be RUN (drop_cnt=0) and FLUSH (drop_cnt>0); FLUSH->RUN on the last dropped response; RUN->FLUSH on redirect with responses still in flight.
REQ-026 On redirect the block SHALL, in that cycle, clear the FIFO, ignore inst_ready, deassert mem_req, and load fetch_pc and resp_pc with {redirect_addr[31:2],2'b00}.
REQ-027 On redirect, drop_cnt SHALL be set to outstanding minus 1 if mem_rvalid is asserted that cycle, otherwise to outstanding; that same-cycle response SHALL be discarded.
REQ-028 Redirect during FLUSH SHALL recompute drop_cnt per REQ-027, not accumulate it.
REQ-029 Issuing SHALL continue in FLUSH; dropped requests consume credit until they return.

Reset
REQ-030 While rst=1: fetch_pc=resp_pc=RESET_PC, outstanding=drop_cnt=0, FIFO empty, state RUN, inst_valid=0, mem_req=0, inst=0, inst_addr=0.
REQ-031 After rst falls, mem_req SHALL assert in the first clock cycle with mem_addr=RESET_PC.
REQ-032 Reset mid-transaction SHALL abandon in-flight requests; the memory side is reset together with this block.

Structure
REQ-033 Package fetch_pkg SHALL hold ADDR_W=32, INST_W=32, PC_STEP=4 and the default RESET_PC, plus the RUN/FLUSH state type.
REQ-034 The FIFO SHALL be a separate sub-module, fetch_fifo (DEPTH entries, push/pop/flush, count output); all credit and drop logic stays in fetch_unit.

Verification
REQ-035 Reset then mem_gnt=1, 1-cycle rvalid, inst_ready=1 -> addresses 0x0, 0x4, 0x8 in order; inst_addr matches each returned word.
REQ-036 inst_ready=0 with memory granting -> exactly 2 requests issued, then mem_req=0; inst_ready=1 -> one pop re-enables one request.
REQ-037 Two requests outstanding, redirect to 0x0000_0102 -> next mem_addr=0x0000_0100; the two stale responses are dropped; first inst_addr=0x100.
REQ-038 Redirect in the same cycle as mem_rvalid with outstanding=1 -> drop_cnt=0, state RUN, the returned word is never presented.
REQ-039 RESET_PC=0xFFFF_FFF8 -> issue sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-040 rst asserted asynchronously with FIFO full and 2 outstanding -> outputs reach reset values immediately, and the first post-reset mem_addr=RESET_PC.
